// File: rtl/fetch_miss_ctrl.sv
// Fetch sequencer: returns cache hits in one cycle, otherwise requests memory
// with a bounded ack window and a limited number of retries.
module fetch_miss_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 5,
    parameter int RETRY_MAX   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              cache_hit,
    input  logic [DATA_W-1:0] cache_data,
    output logic              req,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam int WAIT_W = ($clog2(ACK_TIMEOUT + 1) < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam int ATT_W  = ($clog2(RETRY_MAX + 1) < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(ACK_TIMEOUT);
    localparam logic [ATT_W-1:0]  RETRY_LAST = ATT_W'(RETRY_MAX);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HIT  = 3'd1,
        REQ  = 3'd2,
        GAP  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t              state_reg;
    logic [WAIT_W-1:0]   wait_cnt_reg;
    logic [ATT_W-1:0]    attempt_cnt_reg;
    logic                req_reg;
    logic [ADDR_W-1:0]   req_addr_reg;
    logic                data_ready_reg;
    logic [DATA_W-1:0]   data_out_reg;
    logic                done_reg;
    logic                err_reg;
    logic                busy_reg;

    // All outputs are registered: each transition loads the values the
    // destination state must present.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            wait_cnt_reg    <= '0;
            attempt_cnt_reg <= '0;
            req_reg         <= 1'b0;
            req_addr_reg    <= '0;
            data_ready_reg  <= 1'b0;
            data_out_reg    <= '0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            data_ready_reg <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (fetch) begin
                        busy_reg <= 1'b1;
                        if (cache_hit) begin
                            state_reg      <= HIT;
                            data_ready_reg <= 1'b1;
                            done_reg       <= 1'b1;
                            data_out_reg   <= cache_data;
                        end else begin
                            state_reg       <= REQ;
                            req_reg         <= 1'b1;
                            req_addr_reg    <= fetch_addr;
                            attempt_cnt_reg <= '0;
                            wait_cnt_reg    <= '0;
                        end
                    end
                end
                HIT: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                REQ: begin
                    // An ack in the first request cycle is too early to trust;
                    // an ack on the final window cycle beats the timeout.
                    if (ack && (wait_cnt_reg != '0)) begin
                        state_reg      <= FIN;
                        req_reg        <= 1'b0;
                        data_ready_reg <= 1'b1;
                        done_reg       <= 1'b1;
                        data_out_reg   <= mem_data;
                    end else if (wait_cnt_reg >= WAIT_LAST) begin
                        req_reg <= 1'b0;
                        if (attempt_cnt_reg < RETRY_LAST) begin
                            attempt_cnt_reg <= attempt_cnt_reg + 1'b1;
                            state_reg       <= GAP;
                        end else begin
                            state_reg <= FIN;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    state_reg    <= REQ;
                    req_reg      <= 1'b1;
                    wait_cnt_reg <= '0;
                end
                FIN: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign req        = req_reg;
    assign req_addr   = req_addr_reg;
    assign data_ready = data_ready_reg;
    assign data_out   = data_out_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_fetch_miss_ctrl.sv
// Scoreboard bench for fetch_miss_ctrl: a driver predicts each fetch outcome from
// the ack schedule it plans, and a monitor checks done/req as they appear.
module tb_fetch_miss_ctrl;

    localparam int AT   = 5;
    localparam int RM   = 2;
    localparam int MAXC = 12000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch;
    logic [31:0] fetch_addr;
    logic        cache_hit;
    logic [31:0] cache_data;
    logic        req;
    logic [31:0] req_addr;
    logic        ack;
    logic [31:0] mem_data;
    logic        data_ready;
    logic [31:0] data_out;
    logic        done;
    logic        err;
    logic        busy;

    fetch_miss_ctrl #(
        .ADDR_W(32), .DATA_W(32), .ACK_TIMEOUT(AT), .RETRY_MAX(RM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch(fetch), .fetch_addr(fetch_addr),
        .cache_hit(cache_hit), .cache_data(cache_data), .req(req),
        .req_addr(req_addr), .ack(ack), .mem_data(mem_data),
        .data_ready(data_ready), .data_out(data_out), .done(done),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          err;
        bit          dr;
        logic [31:0] data;
        bit          chk_addr;
        logic [31:0] addr;
    } sb_t;

    sb_t         sb[$];
    bit          exp_req[MAXC];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Attempt a starts req at offset 1+a*(AT+2); acks count at offsets start+1..start+AT.
    function automatic void model(input logic [63:0] mask, output int d, output bit e, output int ao);
        for (int a = 0; a <= RM; a++) begin
            int s = 1 + a * (AT + 2);
            for (int o = s + 1; o <= s + AT; o++) begin
                if (mask[o]) begin
                    d = o + 1; e = 1'b0; ao = o;
                    return;
                end
            end
        end
        d  = 1 + RM * (AT + 2) + AT + 1;
        e  = 1'b1;
        ao = -1;
    endfunction

    task automatic set_req_windows(input int t0, input int d);
        for (int a = 0; a <= RM; a++) begin
            int s = 1 + a * (AT + 2);
            if (s < d) begin
                for (int o = s; o <= s + AT && o < d; o++)
                    if (t0 + o < MAXC) exp_req[t0 + o] = 1'b1;
            end
        end
    endtask

    task automatic do_hit(input logic [31:0] data);
        sb_t ent;
        int  t0 = cyc;
        ent = '{cyc: t0 + 1, err: 1'b0, dr: 1'b1, data: data, chk_addr: 1'b0, addr: '0};
        sb.push_back(ent);
        last_data  = data;
        fetch      = 1'b1;
        cache_hit  = 1'b1;
        cache_data = data;
        fetch_addr = $urandom;
        ack        = 1'($urandom_range(0, 1));
        mem_data   = $urandom;
        step();
        // busy during HIT: this fetch must be dropped
        fetch      = 1'($urandom_range(0, 1));
        cache_hit  = 1'($urandom_range(0, 1));
        cache_data = $urandom;
        ack        = 1'($urandom_range(0, 1));
        step();
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [63:0] mask, input logic [31:0] base);
        sb_t ent;
        int  d, ao;
        bit  e;
        int  t0 = cyc;
        model(mask, d, e, ao);
        set_req_windows(t0, d);
        ent = '{cyc: t0 + d, err: e, dr: !e, data: (e ? last_data : base + 32'(ao)),
                chk_addr: 1'b1, addr: addr};
        sb.push_back(ent);
        if (!e) last_data = base + 32'(ao);
        for (int o = 0; o <= d; o++) begin
            fetch      = (o == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            fetch_addr = (o == 0) ? addr : $urandom;
            cache_hit  = (o == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            cache_data = $urandom;
            ack        = mask[o];
            mem_data   = base + 32'(o);
            step();
        end
    endtask

    task automatic do_idle(input int n);
        for (int i = 0; i < n; i++) begin
            fetch    = 1'b0;
            ack      = 1'($urandom_range(0, 1));
            mem_data = $urandom;
            step();
        end
    endtask

    // Miss with no ack, reset pulsed at offset 9: no done, outputs cleared after.
    task automatic do_miss_reset(input logic [31:0] addr);
        int t0 = cyc;
        for (int o = 1; o <= 6; o++) exp_req[t0 + o] = 1'b1;
        exp_req[t0 + 8] = 1'b1;
        exp_req[t0 + 9] = 1'b1;
        for (int o = 0; o <= 9; o++) begin
            fetch      = (o == 0);
            fetch_addr = addr;
            cache_hit  = 1'b0;
            ack        = 1'b0;
            rst_n      = (o != 9);
            step();
        end
        rst_n = 1'b1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ctrl", {req, done, data_ready, err}, 0);
        chk("rst_mid_data", data_out, 0);
        chk("rst_mid_addr", req_addr, 0);
        last_data = '0;
        for (int i = 0; i < 4; i++) begin
            fetch    = 1'b0;
            ack      = 1'b1;
            mem_data = $urandom;
            step();
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports done.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    chk("missed_done", 0, 1);
                end
                if (done) begin
                    if (sb.size() == 0 || sb[0].cyc != cyc) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("err", err, e.err);
                        chk("data_ready", data_ready, e.dr);
                        chk("data_out", data_out, e.data);
                        if (e.chk_addr) chk("req_addr", req_addr, e.addr);
                    end
                end else if (data_ready) begin
                    chk("stray_data_ready", 1, 0);
                end
                if (cyc < MAXC) chk("req", req, exp_req[cyc]);
            end
        end
    end

    initial begin
        logic [63:0] m;
        rst_n      = 1'b0;
        fetch      = 1'b1;
        fetch_addr = 32'h5555_0000;
        cache_hit  = 1'b0;
        cache_data = '0;
        ack        = 1'b1;
        mem_data   = 32'hABCD_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_ctrl", {req, busy, done, data_ready, err}, 0);
            chk("reset_data", data_out, 0);
            chk("reset_addr", req_addr, 0);
            mon_en = 1'b1;
        end
        rst_n = 1'b1;
        do_hit(32'hDEAD_BEEF);
        do_miss(32'h0000_1000, 64'h1 << 4, 32'h0000_1230);
        do_idle(1);
        do_miss(32'h0000_2000, (64'h1 << 1) | (64'h1 << 3), $urandom);
        do_miss(32'h0000_3000, 64'h1 << 6, $urandom);
        do_miss(32'h0000_4000, 64'h1 << 10, $urandom);
        do_miss(32'h0000_5000, (64'h1 << 0) | (64'h1 << 7) | (64'h1 << 14), $urandom);
        do_miss_reset(32'h0000_6000);
        do_hit(32'h0BAD_F00D);
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 3) begin
                do_hit($urandom);
            end else begin
                m = '0;
                for (int o = 0; o < 24; o++)
                    m[o] = ($urandom_range(0, 11) == 0);
                do_miss($urandom, m, $urandom);
            end
            do_idle(int'($urandom_range(0, 2)));
        end
        do_idle(30);
        chk("drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_miss_ctrl.md
# fetch_miss_ctrl

Fetch sequencer that drives the fetch/cache-hit/req/ack protocol checked by the fetch-path assertions. On a cache hit it returns cached data one cycle after `fetch`. On a miss it raises `req` toward memory and waits a bounded window for `ack`, retrying on timeout. It reports completion on `done` (with `err` on give-up) and presents returned data with a one-cycle `data_ready` pulse.

## Interface
- `ADDR_W`, 32, fetch address width
- `DATA_W`, 32, data width
- `ACK_TIMEOUT`, 5, last cycle after `req` rise in which `ack` is accepted (≥1)
- `RETRY_MAX`, 2, extra attempts after the first timeout (≥0)
- `clk`  in  1  clock; all logic on posedge
- `rst_n`  in  1  synchronous, active-low reset
- `fetch`  in  1  fetch request; sampled only when `busy`=0
- `fetch_addr`  in  ADDR_W  address, valid with `fetch`
- `cache_hit`  in  1  hit indication, valid in the same cycle as `fetch`
- `cache_data`  in  DATA_W  hit data, valid with `cache_hit`
- `req`  out  1  memory request, level
- `req_addr`  out  ADDR_W  address held for the whole transaction
- `ack`  in  1  memory acknowledge
- `mem_data`  in  DATA_W  memory data, valid with `ack`
- `data_ready`  out  1  one-cycle pulse; `data_out` valid
- `data_out`  out  DATA_W  returned data, held until next `data_ready`
- `done`  out  1  one-cycle pulse at end of every accepted fetch
- `err`  out  1  valid with `done`; 1 = retries exhausted
- `busy`  out  1  transaction in flight; `fetch` ignored

## Operation
- States: IDLE, HIT, REQ, GAP, FIN.
- IDLE:
  - `fetch`&`cache_hit` → HIT; latch `cache_data`.
  - `fetch`&!`cache_hit` → REQ; latch `fetch_addr` into `req_addr`; attempt counter cleared; wait counter cleared.
  - `ack` in IDLE is ignored.
- HIT (one cycle): `data_ready`=1, `done`=1, `err`=0, `busy`=1, `data_out`=latched hit data → IDLE.
- REQ: `req`=1; wait counter increments each cycle.
  - The first REQ cycle is wait count 0. `ack` in this cycle is ignored.
  - `ack` at wait count 1..ACK_TIMEOUT: capture `mem_data` → FIN (ok).
  - No `ack` by count ACK_TIMEOUT:
    - if attempts < RETRY_MAX: increment attempts → GAP;
    - otherwise → FIN (err).
- GAP (one cycle): `req`=0; `ack` ignored → REQ with wait counter cleared.
- FIN (one cycle): `done`=1, `busy`=1, `req`=0.
  - ok: `data_ready`=1, `err`=0, `data_out`=captured data.
  - err: `data_ready`=0, `err`=1, `data_out` unchanged.
  - → IDLE.
- `fetch` while `busy`=1 is dropped; it is not queued.
- `req_addr` holds its value after the transaction until the next miss.
- Counters are sized `$clog2(ACK_TIMEOUT+1)` and `$clog2(RETRY_MAX+1)` (minimum 1 bit). They saturate and never wrap.

## Timing
- Reset (`rst_n`=0 at a posedge): next cycle state=IDLE, and `req`, `req_addr`, `data_ready`, `data_out`, `done`, `err`, `busy` all 0; counters 0.
- Reset mid-transaction aborts it. No `done` is emitted, and an `ack` arriving later is ignored.
- `busy` = (state != IDLE), registered.
- Hit: `fetch` at T → `data_ready`/`done` at T+1 (satisfies `cache_hit |=> data_ready`). Next fetch is accepted at T+2.
- Miss: `fetch` at T → `req` at T+1.
  - `ack` at T+1+k (k=1..ACK_TIMEOUT) → `req` low and `data_ready`/`done` at T+2+k.
  - Next fetch is accepted at T+3+k.
- Timeout attempt: `req` high ACK_TIMEOUT+1 cycles, then one low cycle (GAP), then the next attempt.
- Full failure: `req` rises at T+1; the final `done`/`err` comes at T+1+(RETRY_MAX+1)(ACK_TIMEOUT+1)+RETRY_MAX.
  - Defaults: T+21.
- `ack` and timeout in the same cycle (count = ACK_TIMEOUT): `ack` wins.
- `fetch`&`cache_hit` with X on `cache_data` is the caller's error; the block does not check it.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `fetch`=1 → all outputs 0 and `busy`=0 throughout. The first release cycle accepts a fetch.
- Hit: `fetch`=1, `cache_hit`=1, `cache_data`=0xDEAD_BEEF at T → `data_ready`=`done`=1 at T+1, `data_out`=0xDEADBEEF, `req` never high. A second `fetch` at T+1 is dropped.
- Miss with ack: `fetch` at T, addr 0x1000, `ack` at T+4 with `mem_data`=0x1234 → `req` high at T+1..T+4, `req_addr`=0x1000, `data_ready`/`done` at T+5, `err`=0.
- Ack edges:
  - `ack` in the first `req` cycle only → ignored, transaction continues.
  - `ack` exactly at count 5 → accepted, no retry.
- One retry: no `ack` in the first window, `ack` at count 2 of the second attempt → `req` low for exactly one cycle at T+7, success `done` at T+11.
- Exhaustion and reset: no `ack` ever → 3 `req` bursts of 6 cycles, `done`=`err`=1 at T+21, `data_ready`=0, `data_out` unchanged. A repeat run with `rst_n` pulsed at T+9 → no `done`, IDLE next cycle.
